// File: rtl/motion_highlight.sv
// motion_highlight: last stage of the motion-detect pipeline.
// Pops one mask byte and one BGR pixel per pixel, and writes either the
// highlight colour (motion) or the untouched pixel to the output FIFO.
// Tracks the position within a WIDTH*HEIGHT frame and flags its last pixel.
module motion_highlight #(
  parameter int          WIDTH    = 720,
  parameter int          HEIGHT   = 540,
  parameter logic [23:0] HL_COLOR = 24'hFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  mask_fifo_dout,
  input  logic        mask_fifo_empty,
  output logic        mask_fifo_rd_en,
  input  logic [23:0] frame_fifo_dout,
  input  logic        frame_fifo_empty,
  output logic        frame_fifo_rd_en,
  output logic [23:0] out_fifo_din,
  output logic        out_fifo_wr_en,
  input  logic        out_fifo_full,
  output logic [19:0] pixel_count,
  output logic        frame_done
);

  localparam logic [19:0] FRAME_LAST = 20'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_LATCH = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t      state;
  logic        pop;
  logic        mask_hit_p1;
  logic [23:0] pixel_p1;
  logic        last_pixel;

  // Both FIFOs are popped together or not at all, so mask and pixel stay
  // aligned. Gated by reset so nothing is popped while reset is held.
  assign pop = (state == S_READ) && !reset && !mask_fifo_empty && !frame_fifo_empty;

  assign mask_fifo_rd_en  = pop;
  assign frame_fifo_rd_en = pop;

  // Write whenever a captured pixel is waiting and the output has room.
  assign out_fifo_wr_en = (state == S_WRITE) && !reset && !out_fifo_full;
  assign out_fifo_din   = mask_hit_p1 ? HL_COLOR : pixel_p1;

  assign last_pixel = (pixel_count == FRAME_LAST);
  assign frame_done = out_fifo_wr_en && last_pixel;

  // FSM sequencing pop -> capture -> write, holding the capture while full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_READ;
      mask_hit_p1 <= 1'b0;
      pixel_p1    <= 24'h000000;
    end else begin
      case (state)
        S_READ: begin
          if (pop) state <= S_LATCH;
        end
        // ---- p1: FIFO data arrives one cycle after the pop ----
        S_LATCH: begin
          mask_hit_p1 <= (mask_fifo_dout != 8'h00);
          pixel_p1    <= frame_fifo_dout;
          state       <= S_WRITE;
        end
        // ---- p2: write out, or stall with data held ----
        S_WRITE: begin
          if (!out_fifo_full) state <= S_READ;
        end
        default: state <= S_READ;
      endcase
    end
  end

  // Per-frame pixel counter, wrapping after the last pixel of the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_count <= 20'd0;
    end else if (out_fifo_wr_en) begin
      pixel_count <= last_pixel ? 20'd0 : pixel_count + 20'd1;
    end
  end

endmodule

// File: tb/tb_motion_highlight.sv
// Directed testbench for motion_highlight (WIDTH=4, HEIGHT=2 for short frames).
module tb_motion_highlight;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mask_fifo_dout;
  logic        mask_fifo_empty;
  logic        mask_fifo_rd_en;
  logic [23:0] frame_fifo_dout;
  logic        frame_fifo_empty;
  logic        frame_fifo_rd_en;
  logic [23:0] out_fifo_din;
  logic        out_fifo_wr_en;
  logic        out_fifo_full;
  logic [19:0] pixel_count;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Simple standard (non-FWFT) FIFO models for the two inputs.
  logic [7:0]  mask_mem  [0:63];
  logic [23:0] frame_mem [0:63];
  int mask_wr = 0, mask_rd = 0, frame_wr = 0, frame_rd = 0;

  // Output FIFO capture.
  logic [23:0] out_mem [0:63];
  logic [19:0] pc_mem  [0:63];
  logic        fd_mem  [0:63];
  int out_wr = 0;

  assign mask_fifo_empty  = (mask_wr == mask_rd);
  assign frame_fifo_empty = (frame_wr == frame_rd);

  always #5 clk = ~clk;

  motion_highlight #(.WIDTH(4), .HEIGHT(2), .HL_COLOR(24'hFF0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .mask_fifo_dout   (mask_fifo_dout),
    .mask_fifo_empty  (mask_fifo_empty),
    .mask_fifo_rd_en  (mask_fifo_rd_en),
    .frame_fifo_dout  (frame_fifo_dout),
    .frame_fifo_empty (frame_fifo_empty),
    .frame_fifo_rd_en (frame_fifo_rd_en),
    .out_fifo_din     (out_fifo_din),
    .out_fifo_wr_en   (out_fifo_wr_en),
    .out_fifo_full    (out_fifo_full),
    .pixel_count      (pixel_count),
    .frame_done       (frame_done)
  );

  always @(posedge clk) begin
    if (mask_fifo_rd_en) begin
      mask_fifo_dout <= mask_mem[mask_rd];
      mask_rd        <= mask_rd + 1;
    end
    if (frame_fifo_rd_en) begin
      frame_fifo_dout <= frame_mem[frame_rd];
      frame_rd        <= frame_rd + 1;
    end
    if (out_fifo_wr_en) begin
      out_mem[out_wr] <= out_fifo_din;
      pc_mem[out_wr]  <= pixel_count;
      fd_mem[out_wr]  <= frame_done;
      out_wr          <= out_wr + 1;
    end
  end

  task automatic push_mask(input logic [7:0] m);
    mask_mem[mask_wr] = m;
    mask_wr = mask_wr + 1;
  endtask

  task automatic push_frame(input logic [23:0] p);
    frame_mem[frame_wr] = p;
    frame_wr = frame_wr + 1;
  endtask

  task automatic push_pixel(input logic [7:0] m, input logic [23:0] p);
    push_mask(m);
    push_frame(p);
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    int n = 0;
    while (out_wr < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (out_wr >= target);
  endtask

  task automatic test_reset;
    bit ok;
    push_pixel(8'h00, 24'hABCDEF);
    repeat (3) @(negedge clk);
    #1;
    total++; if (mask_fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_mask_rd got=%b want=0", mask_fifo_rd_en); end
    total++; if (frame_fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_frame_rd got=%b want=0", frame_fifo_rd_en); end
    total++; if (out_fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b want=0", out_fifo_wr_en); end
    total++; if (pixel_count !== 20'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", pixel_count); end
    total++; if (out_fifo_din !== 24'h0) begin bad++; $display("FAIL reset_din got=%h want=000000", out_fifo_din); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({mask_fifo_rd_en, frame_fifo_rd_en} !== 2'b11) begin bad++; $display("FAIL release_pop got=%b want=11", {mask_fifo_rd_en, frame_fifo_rd_en}); end
    wait_writes(1, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL release_write_timeout got=%0d want=1", out_wr); end
    total++; if (out_mem[0] !== 24'hABCDEF) begin bad++; $display("FAIL release_data got=%h want=abcdef", out_mem[0]); end
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    push_pixel(8'h00, 24'h123456);
    #1;
    total++; if ({mask_fifo_rd_en, frame_fifo_rd_en} !== 2'b11) begin bad++; $display("FAIL pass_pop got=%b want=11", {mask_fifo_rd_en, frame_fifo_rd_en}); end
    total++; if (out_fifo_wr_en !== 1'b0) begin bad++; $display("FAIL pass_wr_c0 got=%b want=0", out_fifo_wr_en); end
    @(negedge clk);
    total++; if ({mask_fifo_rd_en, frame_fifo_rd_en, out_fifo_wr_en} !== 3'b000) begin bad++; $display("FAIL pass_c1 got=%b want=000", {mask_fifo_rd_en, frame_fifo_rd_en, out_fifo_wr_en}); end
    @(negedge clk);
    total++; if (out_fifo_wr_en !== 1'b1) begin bad++; $display("FAIL pass_wr_c2 got=%b want=1", out_fifo_wr_en); end
    total++; if (out_fifo_din !== 24'h123456) begin bad++; $display("FAIL pass_din got=%h want=123456", out_fifo_din); end
    @(negedge clk);
    total++; if (out_fifo_wr_en !== 1'b0) begin bad++; $display("FAIL pass_wr_c3 got=%b want=0", out_fifo_wr_en); end
  endtask

  task automatic test_highlight;
    bit ok;
    int base = out_wr;
    push_pixel(8'hFF, 24'h123456);
    push_pixel(8'h01, 24'h123456);
    push_pixel(8'h00, 24'h654321);
    wait_writes(base + 3, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL hl_timeout got=%0d want=%0d", out_wr, base + 3); end
    total++; if (out_mem[base] !== 24'hFF0000) begin bad++; $display("FAIL hl_mask_ff got=%h want=ff0000", out_mem[base]); end
    total++; if (out_mem[base+1] !== 24'hFF0000) begin bad++; $display("FAIL hl_mask_01 got=%h want=ff0000", out_mem[base+1]); end
    total++; if (out_mem[base+2] !== 24'h654321) begin bad++; $display("FAIL hl_mask_00 got=%h want=654321", out_mem[base+2]); end
  endtask

  task automatic test_backpressure;
    int base;
    @(negedge clk);
    out_fifo_full = 1'b1;
    push_pixel(8'h00, 24'h0A0B0C);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total++; if (out_fifo_wr_en !== 1'b0) begin bad++; $display("FAIL full_wr c%0d got=%b want=0", i, out_fifo_wr_en); end
      total++; if (out_fifo_din !== 24'h0A0B0C) begin bad++; $display("FAIL full_din c%0d got=%h want=0a0b0c", i, out_fifo_din); end
      @(negedge clk);
    end
    base = out_wr;
    out_fifo_full = 1'b0;
    #1;
    total++; if (out_fifo_wr_en !== 1'b1) begin bad++; $display("FAIL unfull_wr got=%b want=1", out_fifo_wr_en); end
    total++; if (out_fifo_din !== 24'h0A0B0C) begin bad++; $display("FAIL unfull_din got=%h want=0a0b0c", out_fifo_din); end
    @(negedge clk);
    total++; if (out_wr !== base + 1) begin bad++; $display("FAIL unfull_count got=%0d want=%0d", out_wr, base + 1); end
    total++; if (out_fifo_wr_en !== 1'b0) begin bad++; $display("FAIL unfull_single got=%b want=0", out_fifo_wr_en); end
    total++; if (out_mem[base] !== 24'h0A0B0C) begin bad++; $display("FAIL unfull_data got=%h want=0a0b0c", out_mem[base]); end
  endtask

  task automatic test_one_empty;
    bit ok;
    logic [19:0] pc0 = pixel_count;
    int base = out_wr;
    push_frame(24'h111111);
    push_frame(24'h222222);
    push_frame(24'h333333);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++; if ({mask_fifo_rd_en, frame_fifo_rd_en} !== 2'b00) begin bad++; $display("FAIL oneempty_pop c%0d got=%b want=00", i, {mask_fifo_rd_en, frame_fifo_rd_en}); end
    end
    total++; if (pixel_count !== pc0) begin bad++; $display("FAIL oneempty_count got=%0d want=%0d", pixel_count, pc0); end
    push_mask(8'h00);
    push_mask(8'h00);
    push_mask(8'h00);
    wait_writes(base + 3, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL oneempty_timeout got=%0d want=%0d", out_wr, base + 3); end
    total++; if ({out_mem[base], out_mem[base+1], out_mem[base+2]} !== {24'h111111, 24'h222222, 24'h333333})
      begin bad++; $display("FAIL oneempty_order got=%h %h %h want=111111 222222 333333", out_mem[base], out_mem[base+1], out_mem[base+2]); end
  endtask

  task automatic test_frame;
    bit ok;
    int base;
    logic [23:0] exp_din;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (pixel_count !== 20'd0) begin bad++; $display("FAIL frame_reset_count got=%0d want=0", pixel_count); end
    base = out_wr;
    for (int i = 0; i < 16; i++) push_pixel(i[0] ? 8'hFF : 8'h00, 24'h100000 + 24'(i));
    wait_writes(base + 16, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL frame_timeout got=%0d want=%0d", out_wr, base + 16); end
    for (int i = 0; i < 16; i++) begin
      exp_din = i[0] ? 24'hFF0000 : 24'h100000 + 24'(i);
      total++; if (out_mem[base+i] !== exp_din) begin bad++; $display("FAIL frame_data w%0d got=%h want=%h", i, out_mem[base+i], exp_din); end
      total++; if (pc_mem[base+i] !== 20'(i % 8)) begin bad++; $display("FAIL frame_count w%0d got=%0d want=%0d", i, pc_mem[base+i], i % 8); end
      total++; if (fd_mem[base+i] !== ((i % 8) == 7)) begin bad++; $display("FAIL frame_done w%0d got=%b want=%b", i, fd_mem[base+i], (i % 8) == 7); end
    end
    total++; if (pixel_count !== 20'd0) begin bad++; $display("FAIL frame_final_count got=%0d want=0", pixel_count); end
  endtask

  initial begin
    reset         = 1'b1;
    out_fifo_full = 1'b0;
    test_reset();
    test_passthrough();
    test_highlight();
    test_backpressure();
    test_one_empty();
    test_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
